uart_lite_tx: RTL and testbench
===============================

Name: uart_lite_tx

Overview:
- Transmit half of the uart_lite core; the counterpart of character_recovery.
- Serialises a parallel character into an async frame on tx_o: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
- clk runs at the same oversampled rate as the receiver. Each bit is held for exactly OVERSAMPLING clk cycles.
- Valid/ready handshake on the parallel side. Optional break generation so frame_error paths can be exercised end to end.

Parameters:
- OVERSAMPLING, 16: clk cycles per bit; must be ≥ 2.
- DATA_BITS, 8: data bits per character, 5..9.
- PARITY, 2: 0 = none, 1 = odd, 2 = even. Parity bit p satisfies ^{char, p} == PARITY[0]; this matches the receiver's check.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  clock (oversampled rate)
- rst  in  1  reset, synchronous, active-high
- char_i  in  DATA_BITS  character to send
- valid_i  in  1  char_i/break_i valid
- break_i  in  1  qualifies valid_i; send a break instead of a character
- ready_o  out  1  transmitter can accept; registered
- tx_o  out  1  serial line, idle high; registered
- busy_o  out  1  frame in progress; registered

Behaviour:
- Frame length:
  - FRAME = OVERSAMPLING*(1+DATA_BITS+PB+STOP_BITS), where PB = (PARITY>0).
  - Defaults give 176 cycles.
- Reset values, held every cycle rst is high: tx_o=1, ready_o=1, busy_o=0, state IDLE, counters 0.
- Reset mid-frame: abort immediately; tx_o returns high on the edge after rst. No partial bits resume.
- Accept: valid_i && ready_o at a rising edge.
  - char_i is latched into the shift register; parity is computed from the latched value.
  - The edge after acceptance is the first start-bit cycle (tx_o=0). ready_o=0 and busy_o=1 from that edge.
  - char_i and valid_i are don't-care while ready_o=0.
- States:
  - IDLE: tx_o=1. Goes to START on accept.
  - START: tx_o=0 for OVERSAMPLING cycles, then DATA.
  - DATA: tx_o = shift_reg[0]. Shift right every OVERSAMPLING cycles. After DATA_BITS bits, go to PARITY if PB, else STOP.
  - PARITY: tx_o = parity bit for OVERSAMPLING cycles, then STOP.
  - STOP: tx_o=1 for STOP_BITS*OVERSAMPLING cycles, then IDLE, or START on a back-to-back accept.
- Timing counters:
  - Sample counter counts 0..OVERSAMPLING-1 and wraps at bit boundaries.
  - Bit counter is sized $clog2(DATA_BITS+1).
  - No off-by-one allowed: every bit is exactly OVERSAMPLING cycles on tx_o.
- Back-to-back:
  - ready_o rises during the final cycle of the last stop bit.
  - An accept at that edge starts the next start bit immediately, giving a frame-to-frame spacing of exactly FRAME cycles.
  - Once ready_o rises, it stays 1 until an accept occurs.
  - busy_o stays 1 across a back-to-back boundary. Otherwise it drops on the edge the FSM enters IDLE.
- Break (break_i=1 at accept):
  - tx_o=0 for (FRAME − STOP_BITS*OVERSAMPLING) cycles, then a normal STOP period.
  - The receiver must flag frame_error.
  - char_i is ignored.
- tx_o is glitch-free: driven only from a flop.

Decomposition:
- Shared package uart_lite_pkg holds:
  - PARITY_NONE/ODD/EVEN constants.
  - Function frame_cycles(OVERSAMPLING, DATA_BITS, PARITY, STOP_BITS).
  - tx state enum.
  - These constants are shared with character_recovery.
- One natural sub-module: uart_lite_bit_timer. It takes OVERSAMPLING, counts samples, and emits a bit_end strobe with a sync clear on rst/accept. The receiver can reuse it.

Test Plan (defaults unless stated):
- Reset, no activity: tx_o=1, ready_o=1, busy_o=0 for 500 cycles.
- Send 0xA5 at edge k:
  - tx_o=0 on cycles k+1..k+16.
  - Data bits 1,0,1,0,0,1,0,1, each 16 cycles.
  - Parity 0 for 16 cycles; stop 1 for 16 cycles.
  - ready_o=1 at cycle k+176.
- Hold valid_i for 0x00 then 0xFF:
  - Second start bit begins exactly 176 cycles after the first.
  - Both parity bits 0; no idle gap.
- PARITY=1, DATA_BITS=7, STOP_BITS=2, send 0x01: 16*(1+7+1+2)=176-cycle frame, parity bit 0, two stop bits.
- rst asserted during data bit 3: tx_o=1 and ready_o=1 on the next edge; next accepted char is sent intact.
- Loopback into character_recovery:
  - All 256 chars produce valid with matching char and no errors.
  - A break produces frame_error and no valid.

Source files
------------

// File: rtl/uart_lite_pkg.sv
// Shared definitions for the uart_lite transmitter and receiver:
// parity encodings, frame length helper and the transmit state enum.
package uart_lite_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Clock cycles from the first start-bit cycle to the end of the last stop bit
  function automatic int frame_cycles(input int oversampling, input int data_bits,
                                      input int parity, input int stop_bits);
    return oversampling * (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_lite_bit_timer.sv
// Oversampling counter shared by the uart_lite transmitter and receiver;
// strobes bit_end on the last sample of each bit period.
module uart_lite_bit_timer #(
  parameter int OVERSAMPLING = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  output logic [$clog2(OVERSAMPLING)-1:0] count,
  output logic                            bit_end
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);

  assign bit_end = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_lite_tx.sv
// Transmit half of uart_lite: serialises a character (or a break) into
// start, data (LSB first), optional parity and stop bits on tx_o.
module uart_lite_tx
  import uart_lite_pkg::*;
#(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] char_i,
  input  logic                 valid_i,
  input  logic                 break_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int CW = $clog2(OVERSAMPLING);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] PRE_END   = CW'(OVERSAMPLING - 2);
  localparam bit HAS_PARITY = (PARITY != PARITY_NONE);
  localparam bit ODD_PARITY = (PARITY == PARITY_ODD);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 ready_d, tx_d, busy_d;
  logic                 accept, bit_end, timer_clear;
  logic [CW-1:0]        sample_cnt;

  assign accept      = valid_i && ready_o;
  assign timer_clear = accept || (state_q == TX_IDLE);

  uart_lite_bit_timer #(
    .OVERSAMPLING(OVERSAMPLING)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .count  (sample_cnt),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      ready_o   <= 1'b1;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      ready_o   <= ready_d;
      tx_o      <= tx_d;
      busy_o    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    ready_d   = ready_o;
    tx_d      = 1'b1;

    unique case (state_q)
      TX_IDLE: ;
      TX_START: begin
        if (bit_end) begin
          state_d   = TX_DATA;
          bit_cnt_d = '0;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_DATA) begin
            state_d   = HAS_PARITY ? TX_PARITY : TX_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          state_d   = TX_STOP;
          bit_cnt_d = '0;
        end
      end
      TX_STOP: begin
        // Raise ready one cycle early so it is visible in the final stop cycle
        if (bit_cnt_q == LAST_STOP && sample_cnt == PRE_END) begin
          ready_d = 1'b1;
        end
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = TX_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // A break is an all-zero character with a zero parity bit
    if (accept) begin
      state_d   = TX_START;
      bit_cnt_d = '0;
      shift_d   = break_i ? '0 : char_i;
      parity_d  = break_i ? 1'b0 : ((^char_i) ^ ODD_PARITY);
      ready_d   = 1'b0;
    end

    unique case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != TX_IDLE);
  end

endmodule

// File: tb/tb_uart_lite_tx.sv
// Self-checking bench for uart_lite_tx: vector table driven back to back
// through a frame scoreboard, plus reset, idle and alternate-config sequences.
module tb_uart_lite_tx;
  import uart_lite_pkg::*;

  localparam int OS    = 16;
  localparam int FRAME = frame_cycles(16, 8, PARITY_EVEN, 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_i = '0;
  logic       valid_i = 1'b0;
  logic       break_i = 1'b0;
  logic       ready_o, tx_o, busy_o;

  logic [6:0] char2 = '0;
  logic       valid2 = 1'b0;
  logic       ready2, tx2, busy2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {
    logic [10:0] bits;
    int          acc;
  } frame_t;

  typedef struct {
    logic [7:0] ch;
    logic       brk;
    logic       exp_par;
  } vec_t;

  frame_t sb_q[$];
  vec_t   vecs[8];
  bit     in_frame = 1'b0;

  always #5 clk = ~clk;

  uart_lite_tx dut (
    .clk    (clk),
    .rst    (rst),
    .char_i (char_i),
    .valid_i(valid_i),
    .break_i(break_i),
    .ready_o(ready_o),
    .tx_o   (tx_o),
    .busy_o (busy_o)
  );

  uart_lite_tx #(
    .OVERSAMPLING(16),
    .DATA_BITS   (7),
    .PARITY      (PARITY_ODD),
    .STOP_BITS   (2)
  ) dut2 (
    .clk    (clk),
    .rst    (rst),
    .char_i (char2),
    .valid_i(valid2),
    .break_i(1'b0),
    .ready_o(ready2),
    .tx_o   (tx2),
    .busy_o (busy2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Waits for ready, then queues the frame the accept edge must produce
  task automatic applyStimulus(input logic [7:0] ch, input logic brk, input logic exp_par,
                               input bit b2b);
    frame_t f;
    int waited = 0;
    @(negedge clk);
    char_i  = ch;
    break_i = brk;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (ready_o !== 1'b1) begin
      checkOutput("ready_timeout", {31'b0, ready_o}, 1);
      valid_i = 1'b0;
    end else begin
      f.bits = brk ? 11'b100_0000_0000 : {1'b1, exp_par, ch, 1'b0};
      f.acc  = cyc + 1;
      if (b2b) checkOutput("b2b_spacing", f.acc - last_acc, FRAME);
      last_acc = f.acc;
      sb_q.push_back(f);
      @(posedge clk);
    end
  endtask

  task automatic drainFrames();
    int w = 0;
    while ((sb_q.size() > 0 || in_frame) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_timeout", {31'b0, (w < 1000)}, 1);
    @(negedge clk);
    checkOutput("idle_after_frame", {29'b0, tx_o, ready_o, busy_o}, 3'b110);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Frame monitor: every bit period must match the queued frame exactly
  initial begin
    frame_t cur;
    int pos = 0;
    bit bit_ok = 1'b1;
    cur.bits = '0;
    cur.acc  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else if (!in_frame && tx_o == 1'b0) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_start", 1, 0);
        end else begin
          cur = sb_q.pop_front();
          checkOutput("start_cycle", cyc, cur.acc);
          checkOutput("busy_in_frame", {31'b0, busy_o}, 1);
          in_frame = 1'b1;
          pos      = 0;
          bit_ok   = 1'b1;
        end
      end
      if (in_frame) begin
        if (tx_o !== cur.bits[pos / OS]) bit_ok = 1'b0;
        if (pos % OS == OS - 1) begin
          checkOutput($sformatf("frame_bit%0d", pos / OS), {31'b0, bit_ok}, 1);
          bit_ok = 1'b1;
        end
        if (pos == FRAME - 2) checkOutput("ready_early", {31'b0, ready_o}, 0);
        if (pos == FRAME - 1) begin
          checkOutput("ready_last_stop", {31'b0, ready_o}, 1);
          in_frame = 1'b0;
        end
        pos++;
      end
    end
  end

  initial begin
    logic [10:0] e2;
    bit ok;

    vecs[0] = '{ch: 8'hA5, brk: 1'b0, exp_par: 1'b0};
    vecs[1] = '{ch: 8'h00, brk: 1'b0, exp_par: 1'b0};
    vecs[2] = '{ch: 8'hFF, brk: 1'b0, exp_par: 1'b0};
    vecs[3] = '{ch: 8'h01, brk: 1'b0, exp_par: 1'b1};
    vecs[4] = '{ch: 8'h80, brk: 1'b0, exp_par: 1'b1};
    vecs[5] = '{ch: 8'h7F, brk: 1'b0, exp_par: 1'b1};
    vecs[6] = '{ch: 8'h3C, brk: 1'b0, exp_par: 1'b0};
    vecs[7] = '{ch: 8'h5A, brk: 1'b1, exp_par: 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset_state", {29'b0, tx_o, ready_o, busy_o}, 3'b110);
    checkOutput("reset_state2", {29'b0, tx2, ready2, busy2}, 3'b110);
    rst = 1'b0;

    repeat (500) begin
      @(negedge clk);
      checkOutput("idle", {29'b0, tx_o, ready_o, busy_o}, 3'b110);
    end

    // Odd parity, 7 data bits, 2 stop bits: 0x01 gives parity 0
    e2 = {2'b11, 1'b0, 7'h01, 1'b0};
    @(negedge clk);
    char2  = 7'h01;
    valid2 = 1'b1;
    checkOutput("dut2_ready", {31'b0, ready2}, 1);
    @(negedge clk);
    valid2 = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 176; i++) begin
      if (tx2 !== e2[i / 16]) ok = 1'b0;
      if (i % 16 == 15) begin
        checkOutput($sformatf("dut2_bit%0d", i / 16), {31'b0, ok}, 1);
        ok = 1'b1;
      end
      if (i == 175) checkOutput("dut2_ready_last", {31'b0, ready2}, 1);
      if (i < 175) @(negedge clk);
    end
    @(negedge clk);
    checkOutput("dut2_idle", {29'b0, tx2, ready2, busy2}, 3'b110);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].ch, vecs[i].brk, vecs[i].exp_par, i > 0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    break_i = 1'b0;
    drainFrames();

    // Reset during data bit 3 must abort, then a fresh frame goes out intact
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (68) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_abort", {29'b0, tx_o, ready_o, busy_o}, 3'b110);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    drainFrames();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
